// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode values, bubble encoding and
// the fetch-stage FSM state type. Decode and control reuse the opcode constants.
package cpu_pkg;

  localparam int              PC_WIDTH     = 16;
  localparam int              INSTR_WIDTH  = 16;
  localparam logic [15:0]     RESET_PC     = 16'h0000;
  localparam logic [15:0]     NOP_INSTR    = 16'h0000;
  localparam logic [3:0]      OP_HLT       = 4'hF;
  localparam int              DRAIN_CYCLES = 3;

  // RUN: normal fetch; DRAIN: HLT in flight, PC frozen; HALTED: core stopped.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC, PC+2 and a
// valid bit. bubble has priority over load; with neither asserted it holds.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int                     PC_W    = PC_WIDTH,
  parameter int                     INSTR_W = INSTR_WIDTH,
  parameter logic [INSTR_W-1:0]     NOP     = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_plus2_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus2_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;

  // Next-state select: bubble, load or hold.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (bubble) begin
      // A bubble keeps the old PC fields; only instr/valid matter downstream.
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus2_d = pc_plus2_i;
      valid_d    = 1'b1;
    end
  end

  // Register update with asynchronous clear to an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// the HLT drain FSM. imem_addr is the PC itself; imem_data is read the same cycle.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                       PC_W       = PC_WIDTH,
  parameter int                       INSTR_W    = INSTR_WIDTH,
  parameter logic [PC_W-1:0]          RST_PC     = RESET_PC,
  parameter logic [INSTR_W-1:0]       NOP        = NOP_INSTR,
  parameter logic [3:0]               HLT_OPCODE = OP_HLT,
  parameter int                       DRAIN_CNT  = DRAIN_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic               hlt
);

  localparam int CNT_W = $clog2(DRAIN_CNT + 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hlt_q, hlt_d;

  logic [PC_W-1:0]  pc_plus2;
  logic             id_load;
  logic             id_bubble;
  logic             is_hlt;

  // PC+2 wraps modulo 2^PC_W.
  assign pc_plus2 = pc_q + PC_W'(2);
  assign is_hlt   = (imem_data[INSTR_W-1 -: 4] == HLT_OPCODE);

  // Next-PC mux, IF/ID control and FSM transitions; priority redirect > flush > stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    hlt_d     = hlt_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d      = redirect_pc;
          id_bubble = 1'b1;
        end else if (flush) begin
          id_bubble = 1'b1;
          if (!stall) pc_d = pc_plus2;
        end else if (!stall) begin
          id_load = 1'b1;
          if (is_hlt) begin
            // PC parks on the HLT address while it drains down the pipe.
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          // An older branch resolved after the HLT was fetched: the HLT is squashed.
          pc_d      = redirect_pc;
          id_bubble = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end else if (!stall) begin
          id_bubble = 1'b1;
          // After DRAIN_CNT bubble edges the HLT has left WB; the next edge halts.
          if (cnt_q == CNT_W'(DRAIN_CNT)) begin
            state_d = ST_HALTED;
            hlt_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        // Frozen until reset.
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // PC, FSM state, drain counter and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      cnt_q   <= '0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      hlt_q   <= hlt_d;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP     (NOP)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (id_load),
    .bubble     (id_bubble),
    .instr_i    (imem_data),
    .pc_i       (pc_q),
    .pc_plus2_i (pc_plus2),
    .instr_o    (if_id_instr),
    .pc_o       (if_id_pc),
    .pc_plus2_o (if_id_pc_plus2),
    .valid_o    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign hlt       = hlt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch sequence, stall, redirect under stall,
// PC wrap, flush, HLT drain/halt and HLT cancelled by redirect.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic [15:0] pc_out;
  logic        hlt;

  logic [15:0] mem [0:32767];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .pc_out         (pc_out),
    .hlt            (hlt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(32'h1000 + (i & 32'hFFF));
    mem[0] = 16'h1A0A;
    mem[1] = 16'h2B0B;
    mem[2] = 16'h3C0C;
    mem[3] = 16'h4D0D;
    mem[16'h0040 >> 1] = 16'h5A5A;

    // Reset state
    stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pc",    32'(pc_out),      32'h0000);
    check("rst_addr",  32'(imem_addr),   32'h0000);
    check("rst_instr", 32'(if_id_instr), 32'h0000);
    check("rst_valid", 32'(if_id_valid), 32'h0);
    check("rst_hlt",   32'(hlt),         32'h0);
    rst_n = 1'b1;

    // Four free-running fetches
    step();
    check("f0_pc",    32'(pc_out),         32'h0002);
    check("f0_instr", 32'(if_id_instr),    32'h1A0A);
    check("f0_idpc",  32'(if_id_pc),       32'h0000);
    check("f0_pp2",   32'(if_id_pc_plus2), 32'h0002);
    check("f0_valid", 32'(if_id_valid),    32'h1);
    step();
    check("f1_pc",    32'(pc_out),      32'h0004);
    check("f1_instr", 32'(if_id_instr), 32'h2B0B);
    check("f1_idpc",  32'(if_id_pc),    32'h0002);
    step();
    check("f2_pc",    32'(pc_out),      32'h0006);
    check("f2_instr", 32'(if_id_instr), 32'h3C0C);
    check("f2_idpc",  32'(if_id_pc),    32'h0004);
    step();
    check("f3_pc",    32'(pc_out),      32'h0008);
    check("f3_instr", 32'(if_id_instr), 32'h4D0D);
    check("f3_idpc",  32'(if_id_pc),    32'h0006);
    check("f3_valid", 32'(if_id_valid), 32'h1);

    // Stall two cycles at PC=4
    do_reset();
    step();
    step();
    check("pre_stall_pc", 32'(pc_out), 32'h0004);
    stall = 1'b1;
    step();
    step();
    check("stall_pc",    32'(pc_out),      32'h0004);
    check("stall_instr", 32'(if_id_instr), 32'h2B0B);
    check("stall_idpc",  32'(if_id_pc),    32'h0002);
    stall = 1'b0;
    step();
    check("unstall_pc",    32'(pc_out),      32'h0006);
    check("unstall_instr", 32'(if_id_instr), 32'h3C0C);

    // Advance to PC=0x10, then redirect under stall
    for (int i = 0; i < 5; i++) step();
    check("pre_redir_pc", 32'(pc_out), 32'h0010);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    stall = 1'b0; redirect = 1'b0;
    check("redir_pc",    32'(pc_out),      32'h0040);
    check("redir_valid", 32'(if_id_valid), 32'h0);
    check("redir_instr", 32'(if_id_instr), 32'h0000);
    step();
    check("tgt_instr", 32'(if_id_instr), 32'h5A5A);
    check("tgt_valid", 32'(if_id_valid), 32'h1);
    check("tgt_idpc",  32'(if_id_pc),    32'h0040);
    check("tgt_pc",    32'(pc_out),      32'h0042);

    // PC wrap at 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    check("wrap_pre_pc", 32'(pc_out), 32'hFFFE);
    step();
    check("wrap_pc",    32'(pc_out),         32'h0000);
    check("wrap_idpc",  32'(if_id_pc),       32'hFFFE);
    check("wrap_pp2",   32'(if_id_pc_plus2), 32'h0000);
    check("wrap_instr", 32'(if_id_instr),    32'h1FFF);

    // Flush without stall: bubble, PC still advances
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_pc",    32'(pc_out),      32'h0002);
    check("flush_valid", 32'(if_id_valid), 32'h0);
    check("flush_instr", 32'(if_id_instr), 32'h0000);

    // HLT at 0x0008: drain then halt
    mem[4] = 16'hF000;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("hlt_lat_instr", 32'(if_id_instr), 32'hF000);
    check("hlt_lat_valid", 32'(if_id_valid), 32'h1);
    check("hlt_lat_pc",    32'(pc_out),      32'h0008);
    for (int i = 0; i < 3; i++) begin
      step();
      check("drain_valid", 32'(if_id_valid), 32'h0);
      check("drain_pc",    32'(pc_out),      32'h0008);
      check("drain_hlt",   32'(hlt),         32'h0);
    end
    step();
    check("halt_hlt", 32'(hlt),    32'h1);
    check("halt_pc",  32'(pc_out), 32'h0008);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    check("halt_redir_hlt", 32'(hlt),    32'h1);
    check("halt_redir_pc",  32'(pc_out), 32'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hlt", 32'(hlt),    32'h0);
    check("async_rst_pc",  32'(pc_out), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // HLT latched, then redirect on the next edge cancels the halt
    for (int i = 0; i < 5; i++) step();
    check("cancel_lat_instr", 32'(if_id_instr), 32'hF000);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    check("cancel_pc",    32'(pc_out),      32'h0020);
    check("cancel_valid", 32'(if_id_valid), 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("cancel_hlt",   32'(hlt),         32'h0);
    check("cancel_run_pc", 32'(pc_out),     32'h0028);
    check("cancel_valid2", 32'(if_id_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
